// File: rtl/ahb3lite_pkg.sv
// AHB3-lite encodings used by the system slaves on the cm3 master path.
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
endpackage

// File: rtl/timer_pkg.sv
// Register map and bus-state encoding of the AHB3-lite timer.
package timer_pkg;
  // Word offsets, i.e. HADDR[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LOAD   = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_PRESC  = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQEN   = 1;
  localparam int CTRL_ONESHOT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;
endpackage

// File: rtl/timer_core.sv
// Prescaled 32-bit down-counter with reload; flags expiry on a tick at zero.
module timer_core #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [31:0]        load_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               count_wr_i,
  input  logic [31:0]        count_wdata_i,
  output logic [31:0]        count_o,
  output logic               expire_o
);
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [31:0]        count_q, count_d;
  logic               tick;

  assign tick     = en_i && (presc_cnt_q == presc_i);
  assign expire_o = tick && (count_q == 32'd0);
  assign count_o  = count_q;

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    count_d     = count_q;
    if (en_i) presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    if (tick) count_d = (count_q == 32'd0) ? load_i : count_q - 32'd1;
    // A software load overrides any decrement or reload in the same cycle
    if (count_wr_i) begin
      presc_cnt_d = '0;
      count_d     = count_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt_q <= '0;
      count_q     <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
    end
  end
endmodule

// File: rtl/ahb3lite_timer.sv
// AHB3-lite slave wrapping timer_core: bus handshake, register file and IRQ.
module ahb3lite_timer
  import ahb3lite_pkg::*, timer_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PRESC_W    = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  output logic                  HREADYOUT,
  input  logic                  HREADY,
  output logic                  HRESP,
  output logic                  IRQ
);
  logic [1:0]         state_q, state_d;
  logic [2:0]         addr_q, addr_d;
  logic               wr_q, wr_d;
  logic               en_q, en_d, irqen_q, irqen_d, oneshot_q, oneshot_d;
  logic [31:0]        load_q, load_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               expired_q, expired_d, irq_q, irq_d;
  logic               accept, wr_en, expire;
  logic [31:0]        count, rdata;
  logic               unused_ok;

  assign unused_ok = &{1'b0, HBURST, HPROT, HTRANS[0], HADDR[1:0], HADDR[HADDR_SIZE-1:5]};

  // Handshake: an address phase is taken when HSEL, HREADY and a NONSEQ/SEQ
  // HTRANS coincide; the data phase follows one cycle later and completes in
  // that cycle, except a non-word size, which stalls once with ERROR.
  assign accept    = HSEL && HREADY && HTRANS[1];
  assign wr_en     = (state_q == ST_DATA) && wr_q;
  assign HREADYOUT = (state_q != ST_ERR1);
  assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = rdata;
  assign IRQ       = irq_q;

  always_comb begin
    state_d = ST_IDLE;
    addr_d  = addr_q;
    wr_d    = wr_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (accept) begin
      addr_d  = HADDR[4:2];
      wr_d    = HWRITE;
      state_d = (HSIZE == HSIZE_WORD) ? ST_DATA : ST_ERR1;
    end
  end

  always_comb begin
    en_d      = en_q;
    irqen_d   = irqen_q;
    oneshot_d = oneshot_q;
    load_d    = load_q;
    presc_d   = presc_q;
    expired_d = expired_q;
    irq_d     = expired_q && irqen_q;
    if (expire && oneshot_q) en_d = 1'b0;
    if (wr_en) begin
      case (addr_q)
        REG_CTRL: begin
          en_d      = HWDATA[CTRL_EN];
          irqen_d   = HWDATA[CTRL_IRQEN];
          oneshot_d = HWDATA[CTRL_ONESHOT];
        end
        REG_LOAD:   load_d  = HWDATA;
        REG_PRESC:  presc_d = HWDATA[PRESC_W-1:0];
        REG_STATUS: if (HWDATA[0]) expired_d = 1'b0;
        default: ;
      endcase
    end
    // Expiry wins over a same-cycle write-1-to-clear
    if (expire) expired_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (state_q == ST_DATA && !wr_q) begin
      case (addr_q)
        REG_CTRL:   rdata = {29'd0, oneshot_q, irqen_q, en_q};
        REG_LOAD:   rdata = load_q;
        REG_COUNT:  rdata = count;
        REG_STATUS: rdata = {31'd0, expired_q};
        REG_PRESC:  rdata = 32'(presc_q);
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      en_q      <= 1'b0;
      irqen_q   <= 1'b0;
      oneshot_q <= 1'b0;
      load_q    <= '0;
      presc_q   <= '0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      en_q      <= en_d;
      irqen_q   <= irqen_d;
      oneshot_q <= oneshot_d;
      load_q    <= load_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
    end
  end

  timer_core #(.PRESC_W(PRESC_W)) u_core (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .en_i         (en_q),
    .load_i       (load_q),
    .presc_i      (presc_q),
    .count_wr_i   (wr_en && addr_q == REG_COUNT),
    .count_wdata_i(HWDATA),
    .count_o      (count),
    .expire_o     (expire)
  );
endmodule
